// File: rtl/sha1_digest_serializer_if.sv
// Digest-in / word-stream-out bundle for sha1_digest_serializer.
// The slave side is the serializer; the master side is the digest producer plus stream consumer.
interface sha1_digest_serializer_if;
    logic         o_tready;
    logic         i_tvalid;
    logic [159:0] i_tdata;
    logic         i_out_tready;
    logic         o_out_tvalid;
    logic [31:0]  o_out_tdata;
    logic [3:0]   o_out_tkeep;
    logic         o_out_tlast;
    logic [15:0]  o_digest_count;

    modport slave (
        input  i_tvalid, i_tdata, i_out_tready,
        output o_tready, o_out_tvalid, o_out_tdata, o_out_tkeep, o_out_tlast, o_digest_count
    );

    modport master (
        output i_tvalid, i_tdata, i_out_tready,
        input  o_tready, o_out_tvalid, o_out_tdata, o_out_tkeep, o_out_tlast, o_digest_count
    );
endinterface

// File: rtl/sha1_digest_serializer.sv
// Buffers 160-bit SHA-1 digests in a small FIFO and streams each one out as five
// 32-bit AXI-Stream beats (A first), counting fully delivered digests.
module sha1_digest_serializer #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    sha1_digest_serializer_if.slave  bus
);
    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_e;

    state_e        state_q, state_d;
    logic [159:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [159:0]  shreg_q, shreg_d;
    logic [2:0]    beat_q, beat_d;
    logic          tvalid_q, tvalid_d;
    logic          tlast_q, tlast_d;
    logic [15:0]   digest_cnt_q, digest_cnt_d;
    logic          push;
    logic          pop;
    logic          fifo_empty;

    assign fifo_empty   = (cnt_q == '0);
    // Ready looks only at the registered occupancy, so a same-cycle pop never reopens a full FIFO.
    assign bus.o_tready = !reset && (cnt_q != CNT_FULL);
    assign push         = bus.i_tvalid && bus.o_tready;

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        beat_d       = beat_q;
        digest_cnt_d = digest_cnt_q;
        pop          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = mem_q[rd_ptr_q];
                    beat_d  = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (bus.i_out_tready) begin
                    if (beat_q == 3'd4) begin
                        digest_cnt_d = digest_cnt_q + 16'd1;
                        beat_d       = '0;
                        // Reload straight from the FIFO so consecutive packets have no idle beat.
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shreg_d = mem_q[rd_ptr_q];
                        end else begin
                            shreg_d = '0;
                            state_d = S_IDLE;
                        end
                    end else begin
                        shreg_d = {shreg_q[127:0], 32'h0000_0000};
                        beat_d  = beat_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        tvalid_d = (state_d == S_SEND);
        tlast_d  = tvalid_d && (beat_d == 3'd4);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + (AW + 1)'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            shreg_q      <= '0;
            beat_q       <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            digest_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            beat_q       <= beat_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            digest_cnt_q <= digest_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.i_tdata;
        end
    end

    assign bus.o_out_tvalid   = tvalid_q;
    assign bus.o_out_tdata    = shreg_q[159:128];
    assign bus.o_out_tkeep    = {4{tvalid_q}};
    assign bus.o_out_tlast    = tlast_q;
    assign bus.o_digest_count = digest_cnt_q;
endmodule
